// File: rtl/smac_out_collect_pkg.sv
// Shared types and constants for the SMAC output collector.
package smac_out_pkg;

  localparam int GROUPS = 8;
  localparam int DATA_W = 128;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef logic [DATA_W-1:0] beat_t;

endpackage

// File: rtl/smac_out_collect_onehot_idx.sv
// One-hot to binary index converter; o_valid is high only when exactly one bit is set.
module onehot_idx #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // OR-encode the set bit positions; the index is only meaningful when o_valid is high.
  always_comb begin
    o_idx   = '0;
    o_valid = (i_onehot != '0) && ((i_onehot & (i_onehot - N'(1))) == '0);
    for (int i = 0; i < N; i++) begin
      if (i_onehot[i]) o_idx = o_idx | IW'(i);
    end
  end

endmodule

// File: rtl/smac_out_collect.sv
// Collects 8 SMAC result beats into group registers and drains them as a valid/ready burst.
// Optional per-lane even parity output is enabled by defining SMAC_OUT_PARITY_EN.
module smac_out_collect
  import smac_out_pkg::*;
#(
  parameter int M      = 16,
  parameter int DATA_W = smac_out_pkg::DATA_W,
  parameter int GROUPS = smac_out_pkg::GROUPS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [GROUPS-1:0]   i_grp_sel,
  input  logic                i_wr_en,
  input  logic                i_cnt_clear,
  input  logic [DATA_W-1:0]   i_res_in,
  output logic                o_fill_rdy,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [DATA_W-1:0]   o_out_data,
  output logic                o_out_last,
`ifdef SMAC_OUT_PARITY_EN
  output logic [DATA_W/M-1:0] o_out_par,
`endif
  output logic                o_err_sel,
  output logic                o_err_ovf
);

  localparam int LANES = DATA_W / M;
  localparam int IW    = $clog2(GROUPS);
  localparam logic [IW-1:0] LAST_PTR = IW'(GROUPS - 1);

  state_t              r_state;
  logic [GROUPS-1:0]   r_filled;
  logic [IW-1:0]       r_rd_ptr;
  logic [DATA_W-1:0]   r_group [GROUPS];
  logic                r_fill_rdy;
  logic                r_out_valid;
  logic                r_out_last;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_err_sel;
  logic                r_err_ovf;

  logic [IW-1:0]       w_idx;
  logic                w_sel_ok;
  logic                w_write;
  logic                w_xfer;
  logic [GROUPS-1:0]   w_filled_next;
  logic [IW-1:0]       w_ptr_next;
  logic [DATA_W-1:0]   w_load_data;
  logic [LANES-1:0]    w_load_par;
  logic [LANES-1:0]    r_out_par;

  onehot_idx #(.N(GROUPS), .IW(IW)) u_onehot_idx (
    .i_onehot (i_grp_sel),
    .o_idx    (w_idx),
    .o_valid  (w_sel_ok)
  );

  assign w_write       = i_wr_en && w_sel_ok && (r_state == FILL) && !i_cnt_clear;
  assign w_filled_next = r_filled | (w_write ? i_grp_sel : '0);
  assign w_xfer        = r_out_valid && i_out_ready;
  assign w_ptr_next    = r_rd_ptr + 1'b1;

  // The first drain beat may be written on the very edge that completes the block, so bypass res_in.
  always_comb begin
    w_load_data = r_group[w_ptr_next];
    if (r_state == FILL) begin
      w_load_data = (w_write && (w_idx == '0)) ? i_res_in : r_group[0];
    end
    w_load_par = '0;
    for (int l = 0; l < LANES; l++) begin
      w_load_par[l] = ^w_load_data[l*M +: M];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= FILL;
      r_filled    <= '0;
      r_rd_ptr    <= '0;
      r_fill_rdy  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_par   <= '0;
      r_err_sel   <= 1'b0;
      r_err_ovf   <= 1'b0;
      for (int g = 0; g < GROUPS; g++) r_group[g] <= '0;
    end else begin
      if (i_wr_en && !w_sel_ok)      r_err_sel <= 1'b1;
      if (i_wr_en && r_state != FILL) r_err_ovf <= 1'b1;

      // Clear aborts the block but leaves stale group contents in place.
      if (i_cnt_clear) begin
        r_state     <= FILL;
        r_filled    <= '0;
        r_rd_ptr    <= '0;
        r_fill_rdy  <= 1'b1;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        case (r_state)
          FILL: begin
            if (w_write) begin
              r_group[w_idx] <= i_res_in;
              r_filled       <= w_filled_next;
            end
            if (w_filled_next == '1) begin
              r_state     <= DRAIN;
              r_fill_rdy  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_last  <= (LAST_PTR == '0);
              r_out_data  <= w_load_data;
              r_out_par   <= w_load_par;
            end
          end
          DRAIN: begin
            if (w_xfer) begin
              if (r_rd_ptr == LAST_PTR) begin
                r_state     <= FILL;
                r_filled    <= '0;
                r_rd_ptr    <= '0;
                r_fill_rdy  <= 1'b1;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
              end else begin
                r_rd_ptr   <= w_ptr_next;
                r_out_data <= w_load_data;
                r_out_par  <= w_load_par;
                r_out_last <= (w_ptr_next == LAST_PTR);
              end
            end
          end
        endcase
      end
    end
  end

  assign o_fill_rdy  = r_fill_rdy;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_out_data  = r_out_data;
  assign o_err_sel   = r_err_sel;
  assign o_err_ovf   = r_err_ovf;
`ifdef SMAC_OUT_PARITY_EN
  assign o_out_par   = r_out_par;
`endif

endmodule

// File: tb/tb_smac_out_collect.sv
// Directed, table-driven bench for smac_out_collect (M=16, 8 groups of 128-bit beats).
module tb_smac_out_collect;
  import smac_out_pkg::*;

  localparam int TB_M = 16;

  typedef struct {
    logic       wrEn;
    logic [7:0] grpSel;
    beat_t      resIn;
    logic       clear;
    logic       outReady;
    logic       expFillRdy;
    logic       expValid;
    logic       expLast;
    beat_t      expData;
    logic       expErrSel;
    logic       expErrOvf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  grpSel;
  logic        wrEn;
  logic        cntClear;
  beat_t       resIn;
  logic        fillRdy;
  logic        outValid;
  logic        outReady;
  beat_t       outData;
  logic        outLast;
  logic        errSel;
  logic        errOvf;
`ifdef SMAC_OUT_PARITY_EN
  logic [7:0]  outPar;
`endif

  int vecCount  = 0;
  int missCount = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  smac_out_collect #(.M(TB_M)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_grp_sel   (grpSel),
    .i_wr_en     (wrEn),
    .i_cnt_clear (cntClear),
    .i_res_in    (resIn),
    .o_fill_rdy  (fillRdy),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_data  (outData),
    .o_out_last  (outLast),
`ifdef SMAC_OUT_PARITY_EN
    .o_out_par   (outPar),
`endif
    .o_err_sel   (errSel),
    .o_err_ovf   (errOvf)
  );

  function automatic beat_t pat(input logic [15:0] v);
    return {8{v}};
  endfunction

  function automatic void addVec(input logic w, input logic [7:0] g, input beat_t r,
                                 input logic c, input logic rdy, input logic eFill,
                                 input logic eValid, input logic eLast, input beat_t eData,
                                 input logic eSel, input logic eOvf);
    vec_t v;
    v.wrEn = w; v.grpSel = g; v.resIn = r; v.clear = c; v.outReady = rdy;
    v.expFillRdy = eFill; v.expValid = eValid; v.expLast = eLast; v.expData = eData;
    v.expErrSel = eSel; v.expErrOvf = eOvf;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs and sample 1ns after the active edge.
  task automatic applyStimulus(input logic w, input logic [7:0] g, input beat_t r,
                               input logic c, input logic rdy);
    wrEn = w; grpSel = g; resIn = r; cntClear = c; outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int id, input logic eFill, input logic eValid,
                             input logic eLast, input beat_t eData, input logic chkData,
                             input logic eSel, input logic eOvf);
    vecCount++;
    if (fillRdy !== eFill) begin
      missCount++; $display("[TB] FAIL vec %0d fill_rdy got %b want %b", id, fillRdy, eFill);
    end
    if (outValid !== eValid) begin
      missCount++; $display("[TB] FAIL vec %0d out_valid got %b want %b", id, outValid, eValid);
    end
    if (outLast !== eLast) begin
      missCount++; $display("[TB] FAIL vec %0d out_last got %b want %b", id, outLast, eLast);
    end
    if (chkData && (outData !== eData)) begin
      missCount++; $display("[TB] FAIL vec %0d out_data got %h want %h", id, outData, eData);
    end
    if (errSel !== eSel) begin
      missCount++; $display("[TB] FAIL vec %0d err_sel got %b want %b", id, errSel, eSel);
    end
    if (errOvf !== eOvf) begin
      missCount++; $display("[TB] FAIL vec %0d err_ovf got %b want %b", id, errOvf, eOvf);
    end
  endtask

  initial begin
    int ptr;
    int k;
    logic rdy;

    // Sequential fill: 0x0000.., 0x1111.., ... then drain with out_ready held high.
    for (int i = 0; i < 7; i++)
      addVec(1, 8'(1 << i), pat(16'(i * 16'h1111)), 0, 1, 1, 0, 0, '0, 0, 0);
    addVec(1, 8'h80, pat(16'h7777), 0, 1, 0, 1, 0, pat(16'h0000), 0, 0);
    for (int i = 1; i < 8; i++)
      addVec(0, 8'h00, '0, 0, 1, 0, 1, (i == 7), pat(16'(i * 16'h1111)), 0, 0);
    addVec(0, 8'h00, '0, 0, 1, 1, 0, 0, '0, 0, 0);

    // Backpressure with an overflow write before the first transfer.
    for (int i = 0; i < 7; i++)
      addVec(1, 8'(1 << i), pat(16'(16'hA0A0 + i)), 0, 0, 1, 0, 0, '0, 0, 0);
    addVec(1, 8'h80, pat(16'hA0A7), 0, 0, 0, 1, 0, pat(16'hA0A0), 0, 0);
    addVec(1, 8'h02, pat(16'hDEAD), 0, 0, 0, 1, 0, pat(16'hA0A0), 0, 1);
    ptr = 0;
    k = 0;
    while (ptr < 8) begin
      rdy = ((k % 4) == 0) || ((k % 4) == 3);
      if (rdy) ptr++;
      addVec(0, 8'h00, '0, 0, rdy, (ptr == 8), (ptr < 8), (ptr == 7),
             (ptr < 8) ? pat(16'(16'hA0A0 + ptr)) : '0, 0, 1);
      k++;
    end

    // Bad selects write nothing; group 2 is rewritten without error.
    addVec(1, 8'h03, pat(16'hBAD1), 0, 1, 1, 0, 0, '0, 1, 1);
    addVec(1, 8'h00, pat(16'hBAD2), 0, 1, 1, 0, 0, '0, 1, 1);
    addVec(1, 8'h04, pat(16'h0BAD), 0, 1, 1, 0, 0, '0, 1, 1);
    for (int i = 2; i < 8; i++)
      addVec(1, 8'(1 << i), pat(16'(16'h5000 + i)), 0, 1, 1, 0, 0, '0, 1, 1);
    addVec(1, 8'h01, pat(16'h5000), 0, 1, 1, 0, 0, '0, 1, 1);
    addVec(1, 8'h02, pat(16'h5001), 0, 1, 0, 1, 0, pat(16'h5000), 1, 1);
    for (int i = 1; i < 8; i++)
      addVec(0, 8'h00, '0, 0, 1, 0, 1, (i == 7), pat(16'(16'h5000 + i)), 1, 1);
    addVec(0, 8'h00, '0, 0, 1, 1, 0, 0, '0, 1, 1);

    // Clear after 5 writes (clear beats a simultaneous write), then 8 fresh writes, group 0 last.
    for (int i = 0; i < 5; i++)
      addVec(1, 8'(1 << i), pat(16'(16'hEE00 + i)), 0, 0, 1, 0, 0, '0, 1, 1);
    addVec(1, 8'h20, pat(16'hEE05), 1, 0, 1, 0, 0, '0, 1, 1);
    for (int i = 5; i < 8; i++)
      addVec(1, 8'(1 << i), pat(16'(16'h3C00 + i)), 0, 0, 1, 0, 0, '0, 1, 1);
    for (int i = 4; i > 0; i--)
      addVec(1, 8'(1 << i), pat(16'(16'h3C00 + i)), 0, 0, 1, 0, 0, '0, 1, 1);
    addVec(1, 8'h01, pat(16'h3C00), 0, 0, 0, 1, 0, pat(16'h3C00), 1, 1);
    for (int i = 1; i < 8; i++)
      addVec(0, 8'h00, '0, 0, 1, 0, 1, (i == 7), pat(16'(16'h3C00 + i)), 1, 1);
    addVec(0, 8'h00, '0, 0, 1, 1, 0, 0, '0, 1, 1);

    // Clear coinciding with a drain transfer, then a new block must restart at group 0.
    for (int i = 0; i < 7; i++)
      addVec(1, 8'(1 << i), pat(16'(16'h7100 + i)), 0, 0, 1, 0, 0, '0, 1, 1);
    addVec(1, 8'h80, pat(16'h7107), 0, 0, 0, 1, 0, pat(16'h7100), 1, 1);
    addVec(0, 8'h00, '0, 0, 1, 0, 1, 0, pat(16'h7101), 1, 1);
    addVec(0, 8'h00, '0, 1, 1, 1, 0, 0, '0, 1, 1);
    addVec(0, 8'h00, '0, 0, 0, 1, 0, 0, '0, 1, 1);
    for (int i = 0; i < 7; i++)
      addVec(1, 8'(1 << i), pat(16'(16'h6200 + i)), 0, 0, 1, 0, 0, '0, 1, 1);
    addVec(1, 8'h80, pat(16'h6207), 0, 0, 0, 1, 0, pat(16'h6200), 1, 1);
    for (int i = 1; i < 4; i++)
      addVec(0, 8'h00, '0, 0, 1, 0, 1, 0, pat(16'(16'h6200 + i)), 1, 1);

    wrEn = 0; grpSel = '0; resIn = '0; cntClear = 0; outReady = 0; rstN = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput(-1, 1, 0, 0, '0, 1, 0, 0);
    rstN = 1;

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].wrEn, vecs[v].grpSel, vecs[v].resIn, vecs[v].clear, vecs[v].outReady);
      checkOutput(v, vecs[v].expFillRdy, vecs[v].expValid, vecs[v].expLast, vecs[v].expData,
                  vecs[v].expValid, vecs[v].expErrSel, vecs[v].expErrOvf);
    end

    // Asynchronous reset while beat 3 is presented.
    wrEn = 0; grpSel = '0; cntClear = 0; outReady = 0;
    #3;
    rstN = 0;
    #1;
    checkOutput(1000, 1, 0, 0, '0, 1, 0, 0);
    @(posedge clk);
    #1;
    rstN = 1;
    applyStimulus(0, 8'h00, '0, 0, 0);
    checkOutput(1001, 1, 0, 0, '0, 1, 0, 0);

`ifdef SMAC_OUT_PARITY_EN
    applyStimulus(1, 8'h01, {4{16'h0003, 16'h0001}}, 0, 0);
    applyStimulus(1, 8'h02, pat(16'h0007), 0, 0);
    for (int i = 2; i < 8; i++) applyStimulus(1, 8'(1 << i), '0, 0, 0);
    vecCount++;
    if (outPar !== 8'h55) begin
      missCount++; $display("[TB] FAIL parity beat0 got %h want %h", outPar, 8'h55);
    end
    applyStimulus(0, 8'h00, '0, 0, 1);
    vecCount++;
    if (outPar !== 8'hFF) begin
      missCount++; $display("[TB] FAIL parity beat1 got %h want %h", outPar, 8'hFF);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
